// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter between several
// byte-stream requesters; a message owns the transmitter until its last byte or a stall timeout.
module serial_tx_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDLE_TIMEOUT   = 100000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [8*NUM_REQUESTERS-1:0]       req_data,
    input  logic [NUM_REQUESTERS-1:0]         req_valid,
    input  logic [NUM_REQUESTERS-1:0]         req_last,
    output logic [NUM_REQUESTERS-1:0]         req_ready,
    output logic [7:0]                        tx_data,
    output logic                              tx_data_available,
    input  logic                              tx_ready,
    output logic [$clog2(NUM_REQUESTERS)-1:0] grant,
    output logic                              busy,
    output logic                              aborted
);

    localparam int GW = $clog2(NUM_REQUESTERS);
    localparam int SW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX  = SW'(IDLE_TIMEOUT);
    localparam logic          TIMEOUT_EN = (IDLE_TIMEOUT != 0);
    localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_REQUESTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [SW-1:0]   stall_q, stall_d;

    logic [7:0]      req_bytes [NUM_REQUESTERS];
    logic            rr_found;
    logic [GW-1:0]   rr_pick;
    logic [GW-1:0]   rr_idx;
    logic            xfer;
    logic            abort_now;
    logic            in_send;

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_bytes
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    // First valid requester strictly after the previous owner, wrapping to 0.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            rr_idx = GW'((int'(last_grant_q) + k) % NUM_REQUESTERS);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    assign xfer = (state_q == ST_SEND) && req_valid[grant_q] && tx_ready;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        abort_now    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    stall_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    stall_d = '0;
                    if (req_last[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = ST_DRAIN;
                    end
                end else if (!req_valid[grant_q]) begin
                    if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
                    if (TIMEOUT_EN && stall_d == STALL_MAX) begin
                        abort_now    = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_IDX;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
        end
    end

    // Outputs are forced quiet while reset is held so a dropped message stops at once.
    assign in_send           = (state_q == ST_SEND) && !reset;
    assign tx_data           = in_send ? req_bytes[grant_q] : 8'h00;
    assign tx_data_available = in_send && req_valid[grant_q];
    assign busy              = !reset && (state_q != ST_IDLE);
    assign aborted           = !reset && abort_now;
    assign grant             = reset ? '0 : grant_q;

    always_comb begin
        req_ready = '0;
        if (in_send) req_ready[grant_q] = tx_ready;
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: requester/transmitter models drive the DUT,
// a round-robin message model predicts the byte stream, a monitor checks each transfer.
module tb_serial_tx_arbiter;

    localparam int NREQ       = 4;
    localparam int TIMEOUT    = 16;
    localparam int BIT_CYCLES = 4;   // bit time scaled down from 5000 to keep the run short
    localparam int GW         = $clog2(NREQ);

    typedef struct packed {
        logic [GW-1:0] req;
        logic [7:0]    data;
    } exp_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [8*NREQ-1:0]    req_data = '0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_last = '0;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_available;
    logic                 tx_ready = 1'b1;
    logic [GW-1:0]        grant;
    logic                 busy;
    logic                 aborted;

    serial_tx_arbiter #(
        .NUM_REQUESTERS (NREQ),
        .IDLE_TIMEOUT   (TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_data          (req_data),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .tx_data           (tx_data),
        .tx_data_available (tx_data_available),
        .tx_ready          (tx_ready),
        .grant             (grant),
        .busy              (busy),
        .aborted           (aborted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Per-requester pending bytes {last, data}; expected transfer stream.
    logic [8:0] pend [NREQ][$];
    int         gap [NREQ];
    int         max_gap   = 0;
    bit         tx_random = 0;
    bit         tx_hold   = 0;
    int         tx_left   = 0;
    exp_t       exp_q [$];
    int         model_last = NREQ - 1;
    int         xfer_cnt = 0;
    int         last_xfer_cyc = 0;
    int         abort_cnt = 0;
    int         seen_grants [$];

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    function automatic bit pend_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic add_msg(input int r, input int len);
        logic [8:0] b;
        for (int j = 0; j < len; j++) begin
            b = {(j == len - 1), 8'($urandom)};
            pend[r].push_back(b);
        end
    endtask

    // Reference model: whole messages served round-robin after the previous owner.
    function automatic void plan();
        int         rd [NREQ];
        int         r;
        int         idx;
        logic [8:0] b;
        exp_t       e;
        for (int i = 0; i < NREQ; i++) rd[i] = 0;
        while (1) begin
            r = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (model_last + k) % NREQ;
                if (r < 0 && rd[idx] < pend[idx].size()) r = idx;
            end
            if (r < 0) break;
            do begin
                b = pend[r][rd[r]];
                rd[r]++;
                e.req  = GW'(r);
                e.data = b[7:0];
                exp_q.push_back(e);
            end while (!b[8] && rd[r] < pend[r].size());
            model_last = r;
        end
    endfunction

    // Requester and transmitter models: sample handshakes at negedge, update after posedge.
    initial begin : driver
        logic [NREQ-1:0] acc;
        bit              cap;
        logic [8:0]      b;
        forever begin
            @(negedge clock);
            acc = req_valid & req_ready;
            cap = tx_ready && tx_data_available;
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && pend[i].size() > 0) begin
                    b = pend[i].pop_front();
                    gap[i] = (pend[i].size() > 0 && !b[8]) ? int'($urandom_range(max_gap, 0)) : 0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (pend[i].size() > 0) begin
                    b = pend[i][0];
                    req_valid[i] = (gap[i] == 0);
                    req_last[i]  = b[8];
                    req_data[8*i +: 8] = b[7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
            if (cap) tx_left = tx_random ? int'($urandom_range(12, 0)) : 10 * BIT_CYCLES;
            else if (tx_left > 0) tx_left--;
            tx_ready = (tx_left == 0) && !tx_hold;
        end
    end

    initial begin : monitor
        exp_t            e;
        logic [NREQ-1:0] allowed;
        forever begin
            @(negedge clock);
            if (tx_data_available && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_xfer", int'(tx_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    check(tx_data == e.data, "tx_data", int'(tx_data), int'(e.data));
                    check(grant == e.req, "xfer_grant", int'(grant), int'(e.req));
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
                seen_grants.push_back(int'(grant));
            end
            if (aborted) abort_cnt++;
            allowed = '0;
            if (busy && tx_ready) allowed[grant] = 1'b1;
            check((req_ready & ~allowed) == '0, "req_ready_rule", int'(req_ready), int'(allowed));
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clock);
            done = (exp_q.size() == 0) && !busy && pend_empty();
            n++;
        end
        check(done, name, n, budget);
        exp_q.delete();
        step();
    endtask

    task automatic wait_pend(input int r, input int size, input string name);
        int n = 0;
        while (pend[r].size() != size && n < 2000) begin
            step();
            n++;
        end
        check(pend[r].size() == size, name, pend[r].size(), size);
    endtask

    // After a message ends: busy stays up until the first tx_ready-high cycle, drops the next.
    task automatic check_drain(input string name);
        int n = 0;
        @(negedge clock);
        while (!tx_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        check(tx_ready && busy, {name, "_busy_until_ready"}, int'(busy), 1);
        @(negedge clock);
        check(!busy, {name, "_busy_fall"}, int'(busy), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base_x;
        int base_a;
        int base_g;
        int rr_order [6];
        int cnt;
        int n;
        logic [8:0] b;
        exp_t e;

        rr_order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < NREQ; i++) gap[i] = 0;

        // Reset state, during and after the reset cycle.
        step(2);
        @(negedge clock);
        check(!busy && !aborted, "busy_aborted_in_reset", int'({busy, aborted}), 0);
        check(req_ready == '0 && !tx_data_available, "ready_avail_in_reset", int'(req_ready), 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check(!busy, "reset_busy", int'(busy), 0);
        check(!aborted, "reset_aborted", int'(aborted), 0);
        check(!tx_data_available, "reset_tx_avail", int'(tx_data_available), 0);
        check(req_ready == '0, "reset_req_ready", int'(req_ready), 0);
        check(tx_data == 8'h00, "reset_tx_data", int'(tx_data), 0);
        check(grant == '0, "reset_grant", int'(grant), 0);
        step();

        // Round robin among 0, 1, 3 with one-byte messages.
        base_g = seen_grants.size();
        for (int r = 0; r < NREQ; r++) if (r != 2) begin
            add_msg(r, 1);
            add_msg(r, 1);
        end
        plan();
        wait_done("rr_done", 2000);
        check(seen_grants.size() == base_g + 6, "rr_count", seen_grants.size() - base_g, 6);
        if (seen_grants.size() >= base_g + 6)
            for (int i = 0; i < 6; i++)
                check(seen_grants[base_g + i] == rr_order[i], "rr_order", seen_grants[base_g + i], rr_order[i]);

        // Single message from requester 2 through a bit-timed transmitter.
        base_x = xfer_cnt;
        base_a = abort_cnt;
        b = {1'b0, 8'h48};
        pend[2].push_back(b);
        b = {1'b1, 8'h69};
        pend[2].push_back(b);
        plan();
        wait_pend(2, 0, "single_accept");
        check_drain("single");
        check(grant == 2'd2, "single_grant", int'(grant), 2);
        check(xfer_cnt - base_x == 2, "single_xfer_count", xfer_cnt - base_x, 2);
        check(abort_cnt == base_a, "single_no_abort", abort_cnt - base_a, 0);
        wait_done("single_done", 200);

        // Ownership: requester 0 waits until requester 1 finishes and drains.
        add_msg(1, 3);
        plan();
        wait_pend(1, 2, "own_first_byte");
        add_msg(0, 1);
        b = pend[0][0];
        e.req  = '0;
        e.data = b[7:0];
        exp_q.push_back(e);
        model_last = 0;
        cnt = 0;
        n = 0;
        do begin
            @(negedge clock);
            if (req_ready[0]) cnt++;
            n++;
        end while (!(pend[1].size() == 0 && !busy) && n < 1000);
        check(cnt == 0, "own_req0_ready_early", cnt, 0);
        wait_done("own_done", 500);

        // Timeout: one byte without last, then silence; requester 1 waits.
        base_a = abort_cnt;
        b = {1'b0, 8'($urandom)};
        pend[0].push_back(b);
        e.req  = '0;
        e.data = b[7:0];
        exp_q.push_back(e);
        wait_pend(0, 0, "abort_byte_accept");
        add_msg(1, 2);
        while (pend[1].size() > 0) begin
            b = pend[1].pop_front();
            e.req  = GW'(1);
            e.data = b[7:0];
            exp_q.push_back(e);
            pend[3].push_back(b);
        end
        while (pend[3].size() > 0) pend[1].push_back(pend[3].pop_front());
        model_last = 1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!aborted && n < 200);
        check(aborted, "abort_seen", int'(aborted), 1);
        check(cyc - last_xfer_cyc == TIMEOUT, "abort_delay", cyc - last_xfer_cyc, TIMEOUT);
        check(busy, "abort_busy", int'(busy), 1);
        @(negedge clock);
        check(!aborted, "abort_one_cycle", int'(aborted), 0);
        check_drain("abort");
        wait_done("abort_done", 500);
        check(abort_cnt - base_a == 1, "abort_pulse_count", abort_cnt - base_a, 1);

        // tx_ready held low with valid high does not count as a stall.
        base_a = abort_cnt;
        tx_hold = 1'b1;
        add_msg(3, 2);
        plan();
        repeat (1000) @(negedge clock);
        check(abort_cnt == base_a, "txready_stall_no_abort", abort_cnt - base_a, 0);
        check(busy && grant == 2'd3, "txready_stall_owner", int'(grant), 3);
        step();
        tx_hold = 1'b0;
        wait_done("txready_stall_done", 500);

        // Reset during byte 2 of a 4-byte message.
        base_a = abort_cnt;
        add_msg(1, 4);
        plan();
        wait_pend(1, 3, "rst_first_byte");
        reset = 1'b1;
        pend[1].delete();
        gap[1] = 0;
        exp_q.delete();
        model_last = NREQ - 1;
        @(negedge clock);
        check(!busy && req_ready == '0 && !tx_data_available, "rst_mid_quiet", int'(busy), 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check(!busy, "rst_mid_busy", int'(busy), 0);
        check(req_ready == '0, "rst_mid_req_ready", int'(req_ready), 0);
        check(grant == '0, "rst_mid_grant", int'(grant), 0);
        step();
        base_g = seen_grants.size();
        add_msg(1, 1);
        add_msg(0, 2);
        plan();
        wait_done("rst_after_done", 1000);
        check(seen_grants.size() > base_g && seen_grants[base_g] == 0, "rst_first_winner",
              (seen_grants.size() > base_g) ? seen_grants[base_g] : -1, 0);
        check(abort_cnt == base_a, "rst_no_abort", abort_cnt - base_a, 0);

        // Randomized traffic: gaps inside messages, random transmitter busy time.
        tx_random = 1'b1;
        max_gap   = 3;
        base_a    = abort_cnt;
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                n = int'($urandom_range(2, 0));
                for (int m = 0; m < n; m++) add_msg(r, int'($urandom_range(4, 1)));
            end
            plan();
            wait_done("random_done", 3000);
        end
        check(abort_cnt == base_a, "random_no_abort", abort_cnt - base_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
